// File: rtl/bin_modinv_engine.sv
// Binary GCD (Stein) / modular inverse (binary extended Euclid) engine with busy/done handshake.
// Optional RUN-cycle counter output enabled by defining BIN_MODINV_CYCLE_CNT_EN.
module bin_modinv_engine #(
    parameter int unsigned NBITS  = 256,
    parameter int unsigned MAXCYC = 4 * NBITS + 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [NBITS-1:0] op_a,
    input  logic [NBITS-1:0] op_m,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] result,
    output logic [NBITS-1:0] gcd_out,
    output logic             no_inv,
    output logic             bad_arg
`ifdef BIN_MODINV_CYCLE_CNT_EN
    ,
    output logic [$clog2(MAXCYC+1)-1:0] cyc_cnt
`endif
);

    localparam int unsigned CW = $clog2(MAXCYC + 1);
    localparam int unsigned KW = $clog2(NBITS + 1);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [NBITS-1:0] m_q, m_d;
    logic [NBITS-1:0] u_q, u_d;
    logic [NBITS-1:0] v_q, v_d;
    logic [NBITS-1:0] x1_q, x1_d;
    logic [NBITS-1:0] x2_q, x2_d;
    logic [KW-1:0]    k_q, k_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NBITS-1:0] result_q, result_d;
    logic [NBITS-1:0] gcd_q, gcd_d;
    logic             no_inv_q, no_inv_d;
    logic             bad_q, bad_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef BIN_MODINV_CYCLE_CNT_EN
    logic [CW-1:0]    cyc_q, cyc_d;
`endif

    // x/2 mod m for odd m; the add needs one carry bit
    function automatic logic [NBITS-1:0] half_mod(input logic [NBITS-1:0] x, input logic [NBITS-1:0] m);
        logic [NBITS:0] s;
        s = {1'b0, x} + {1'b0, m};
        return x[0] ? s[NBITS:1] : (x >> 1);
    endfunction

    // (a - b) mod m with a, b already in [0, m-1]
    function automatic logic [NBITS-1:0] sub_mod(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b,
                                                 input logic [NBITS-1:0] m);
        return (a >= b) ? (a - b) : (a - b + m);
    endfunction

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        m_d      = m_q;
        u_d      = u_q;
        v_d      = v_q;
        x1_d     = x1_q;
        x2_d     = x2_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        gcd_d    = gcd_q;
        no_inv_d = no_inv_q;
        bad_d    = bad_q;
`ifdef BIN_MODINV_CYCLE_CNT_EN
        cyc_d    = cyc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d   = mode;
                    u_d      = op_a;
                    v_d      = op_m;
                    m_d      = op_m;
                    no_inv_d = 1'b0;
                    bad_d    = 1'b0;
                    result_d = '0;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (mode_q && (!v_q[0] || v_q <= NBITS'(1))) begin
                    bad_d   = 1'b1;
                    state_d = S_DONE;
                end else if (u_q == '0 || v_q == '0) begin
                    gcd_d    = u_q | v_q;
                    no_inv_d = mode_q;
                    state_d  = S_DONE;
                end else begin
                    x1_d    = NBITS'(1);
                    x2_d    = '0;
                    k_d     = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
`ifdef BIN_MODINV_CYCLE_CNT_EN
                cyc_d = '0;
`endif
            end
            S_RUN: begin
                // exits are judged on the values before this cycle's operation
                if (mode_q && u_q == NBITS'(1)) begin
                    result_d = x1_q;
                    gcd_d    = NBITS'(1);
                    state_d  = S_DONE;
                end else if (mode_q && v_q == NBITS'(1)) begin
                    result_d = x2_q;
                    gcd_d    = NBITS'(1);
                    state_d  = S_DONE;
                end else if (u_q == '0) begin
                    gcd_d    = mode_q ? v_q : (v_q << k_q);
                    no_inv_d = mode_q;
                    state_d  = S_DONE;
                end else if (cnt_q == CW'(MAXCYC)) begin
                    bad_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (!mode_q && !u_q[0] && !v_q[0]) begin
                        u_d = u_q >> 1;
                        v_d = v_q >> 1;
                        k_d = k_q + KW'(1);
                    end else if (!u_q[0]) begin
                        u_d = u_q >> 1;
                        if (mode_q) x1_d = half_mod(x1_q, m_q);
                    end else if (!v_q[0]) begin
                        v_d = v_q >> 1;
                        if (mode_q) x2_d = half_mod(x2_q, m_q);
                    end else if (u_q >= v_q) begin
                        u_d = u_q - v_q;
                        if (mode_q) x1_d = sub_mod(x1_q, x2_q, m_q);
                    end else begin
                        v_d = v_q - u_q;
                        if (mode_q) x2_d = sub_mod(x2_q, x1_q, m_q);
                    end
                end
`ifdef BIN_MODINV_CYCLE_CNT_EN
                if (state_d == S_DONE) cyc_d = cnt_q;
`endif
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_CHECK) || (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            m_q      <= '0;
            u_q      <= '0;
            v_q      <= '0;
            x1_q     <= '0;
            x2_q     <= '0;
            k_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            gcd_q    <= '0;
            no_inv_q <= 1'b0;
            bad_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef BIN_MODINV_CYCLE_CNT_EN
            cyc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            m_q      <= m_d;
            u_q      <= u_d;
            v_q      <= v_d;
            x1_q     <= x1_d;
            x2_q     <= x2_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            gcd_q    <= gcd_d;
            no_inv_q <= no_inv_d;
            bad_q    <= bad_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef BIN_MODINV_CYCLE_CNT_EN
            cyc_q    <= cyc_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign gcd_out = gcd_q;
    assign no_inv  = no_inv_q;
    assign bad_arg = bad_q;
`ifdef BIN_MODINV_CYCLE_CNT_EN
    assign cyc_cnt = cyc_q;
`endif

endmodule

// File: tb/tb_bin_modinv_engine.sv
// Directed bench for bin_modinv_engine: vector table plus reset, handshake and watchdog sequences.
module tb_bin_modinv_engine;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_m = '0;
    logic         busy, done, no_inv, bad_arg;
    logic [W-1:0] result, gcd_out;

    logic         start2 = 1'b0;
    logic         busy2, done2, no_inv2, bad_arg2;
    logic [W-1:0] result2, gcd_out2;

`ifdef BIN_MODINV_CYCLE_CNT_EN
    logic [$clog2(4*W+4+1)-1:0] cyc_cnt;
    logic [$clog2(4+1)-1:0]     cyc_cnt2;
`endif

    bin_modinv_engine #(.NBITS(W)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .op_a(op_a), .op_m(op_m),
        .busy(busy), .done(done), .result(result), .gcd_out(gcd_out),
        .no_inv(no_inv), .bad_arg(bad_arg)
`ifdef BIN_MODINV_CYCLE_CNT_EN
        , .cyc_cnt(cyc_cnt)
`endif
    );

    // tiny watchdog limit so 319/177 cannot finish in time
    bin_modinv_engine #(.NBITS(W), .MAXCYC(4)) dut_wd (
        .clk(clk), .rst(rst), .start(start2), .mode(1'b1), .op_a(16'd319), .op_m(16'd177),
        .busy(busy2), .done(done2), .result(result2), .gcd_out(gcd_out2),
        .no_inv(no_inv2), .bad_arg(bad_arg2)
`ifdef BIN_MODINV_CYCLE_CNT_EN
        , .cyc_cnt(cyc_cnt2)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         md;
        logic [W-1:0] a;
        logic [W-1:0] m;
        logic [W-1:0] res;
        logic [W-1:0] gcd;
        logic         chk_gcd;
        logic         ninv;
        logic         bad;
        int           lat;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_op(input logic md, input logic [W-1:0] a, input logic [W-1:0] m,
                          output int lat, output bit got);
        @(negedge clk);
        start = 1'b1; mode = md; op_a = a; op_m = m;
        lat = 0; got = 1'b0;
        while (!got && lat < 300) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (done === 1'b1) got = 1'b1;
        end
    endtask

    initial begin
        int  lat;
        bit  got;
        int  ndone;
        logic [W-1:0] res_seen;
        logic [W-1:0] gcd_seen;

        //          md  a    m    res gcd chk ninv bad lat
        vecs[0]  = '{1'b1, 16'd319, 16'd177, 16'd91, 16'd1,   1'b1, 1'b0, 1'b0, 0};
        vecs[1]  = '{1'b0, 16'd48,  16'd18,  16'd0,  16'd6,   1'b1, 1'b0, 1'b0, 0};
        vecs[2]  = '{1'b1, 16'd6,   16'd9,   16'd0,  16'd3,   1'b1, 1'b1, 1'b0, 0};
        vecs[3]  = '{1'b1, 16'd3,   16'd8,   16'd0,  16'd0,   1'b0, 1'b0, 1'b1, 2};
        vecs[4]  = '{1'b1, 16'd0,   16'd177, 16'd0,  16'd177, 1'b1, 1'b1, 1'b0, 2};
        vecs[5]  = '{1'b0, 16'd0,   16'd0,   16'd0,  16'd0,   1'b1, 1'b0, 1'b0, 2};
        vecs[6]  = '{1'b1, 16'd5,   16'd1,   16'd0,  16'd0,   1'b0, 1'b0, 1'b1, 2};
        vecs[7]  = '{1'b0, 16'd12,  16'd0,   16'd0,  16'd12,  1'b1, 1'b0, 1'b0, 2};
        vecs[8]  = '{1'b1, 16'd1,   16'd7,   16'd1,  16'd1,   1'b1, 1'b0, 1'b0, 0};
        vecs[9]  = '{1'b1, 16'd3,   16'd7,   16'd5,  16'd1,   1'b1, 1'b0, 1'b0, 0};
        vecs[10] = '{1'b0, 16'd17,  16'd17,  16'd0,  16'd17,  1'b1, 1'b0, 1'b0, 0};
        vecs[11] = '{1'b1, 16'd10,  16'd7,   16'd5,  16'd1,   1'b1, 1'b0, 1'b0, 0};
        vecs[12] = '{1'b0, 16'd64,  16'd40,  16'd0,  16'd8,   1'b1, 1'b0, 1'b0, 0};

        // reset state
        repeat (2) @(negedge clk);
        check("rst_busy", W'(busy), 0);
        check("rst_done", W'(done), 0);
        check("rst_result", result, 0);
        check("rst_gcd", gcd_out, 0);
        check("rst_no_inv", W'(no_inv), 0);
        check("rst_bad_arg", W'(bad_arg), 0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].md, vecs[i].a, vecs[i].m, lat, got);
            check($sformatf("v%0d_done", i), W'(got), 1);
            check($sformatf("v%0d_result", i), result, vecs[i].res);
            if (vecs[i].chk_gcd) check($sformatf("v%0d_gcd", i), gcd_out, vecs[i].gcd);
            check($sformatf("v%0d_no_inv", i), W'(no_inv), W'(vecs[i].ninv));
            check($sformatf("v%0d_bad_arg", i), W'(bad_arg), W'(vecs[i].bad));
            if (vecs[i].lat != 0) check($sformatf("v%0d_latency", i), W'(lat), W'(vecs[i].lat));
        end

        // reset five cycles into a run aborts it with no done
        @(negedge clk);
        start = 1'b1; mode = 1'b1; op_a = 16'd319; op_m = 16'd177;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy", W'(busy), 1);
        rst = 1'b1;
        #1;
        check("arst_busy", W'(busy), 0);
        check("arst_done", W'(done), 0);
        check("arst_result", result, 0);
        check("arst_gcd", gcd_out, 0);
        check("arst_no_inv", W'(no_inv), 0);
        check("arst_bad_arg", W'(bad_arg), 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (100) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("arst_no_done", W'(ndone), 0);

        // restart; second start while busy must be ignored
        @(negedge clk);
        start = 1'b1; mode = 1'b1; op_a = 16'd319; op_m = 16'd177;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("hs_busy", W'(busy), 1);
        start = 1'b1; mode = 1'b0; op_a = 16'd48; op_m = 16'd18;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; res_seen = '0; gcd_seen = '0;
        repeat (200) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                res_seen = result;
                gcd_seen = gcd_out;
            end
        end
        check("hs_done_count", W'(ndone), 1);
        check("hs_result", res_seen, 16'd91);
        check("hs_gcd", gcd_seen, 16'd1);

        // watchdog expiry: done at MAXCYC+3 edges with bad_arg
        @(negedge clk);
        start2 = 1'b1;
        lat = 0; got = 1'b0;
        while (!got && lat < 300) begin
            @(negedge clk);
            start2 = 1'b0;
            lat++;
            if (done2 === 1'b1) got = 1'b1;
        end
        check("wd_done", W'(got), 1);
        check("wd_latency", W'(lat), 7);
        check("wd_bad_arg", W'(bad_arg2), 1);
        check("wd_result", result2, 0);
        check("wd_no_inv", W'(no_inv2), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
